// File: rtl/bias_loader_fc1.sv
// Runtime fc1 bias loader: collects one bias word per neuron into a shadow
// buffer and publishes the whole packed set atomically on a well-formed last word.
module bias_loader_fc1 #(
  parameter int NUM_NEURONS = 16,
  parameter int BIAS_WIDTH  = 32,
  parameter int DATA_WIDTH  = NUM_NEURONS * BIAS_WIDTH,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BIAS_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  load_done,
  output logic                  load_error,
  output logic [IDX_WIDTH-1:0]  word_idx
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FILL   = 2'd1,
    ST_LOADED = 2'd2
  } st_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  st_t                  st_q, st_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 load_done_q, load_done_d;
  logic                 load_error_q, load_error_d;
  logic                 s_ready_q, s_ready_d;
  logic [BIAS_WIDTH-1:0] shadow_q [NUM_NEURONS];
  logic [BIAS_WIDTH-1:0] shadow_d [NUM_NEURONS];

  logic hs;
  logic at_last_idx;
  st_t  idle_st;

  assign hs          = s_valid && s_ready_q && !clear;
  assign at_last_idx = (idx_q == LAST_IDX);
  // Abandoning a set falls back to whatever is still published.
  assign idle_st     = data_valid_q ? ST_LOADED : ST_EMPTY;

  always_comb begin
    st_d         = st_q;
    idx_d        = idx_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    load_done_d  = 1'b0;
    load_error_d = 1'b0;
    s_ready_d    = 1'b1;
    shadow_d     = shadow_q;

    if (clear) begin
      idx_d = '0;
      st_d  = idle_st;
    end else if (hs) begin
      if (!at_last_idx) begin
        if (s_last) begin
          load_error_d = 1'b1;
          idx_d        = '0;
          st_d         = idle_st;
        end else begin
          shadow_d[idx_q] = s_data;
          idx_d           = idx_q + IDX_WIDTH'(1);
          st_d            = ST_FILL;
        end
      end else if (s_last) begin
        // The final word bypasses the shadow so the commit needs no extra cycle.
        for (int k = 0; k < NUM_NEURONS - 1; k++) begin
          data_d[k*BIAS_WIDTH +: BIAS_WIDTH] = shadow_q[k];
        end
        data_d[(NUM_NEURONS-1)*BIAS_WIDTH +: BIAS_WIDTH] = s_data;
        data_valid_d = 1'b1;
        load_done_d  = 1'b1;
        idx_d        = '0;
        st_d         = ST_LOADED;
      end else begin
        load_error_d = 1'b1;
        idx_d        = '0;
        st_d         = idle_st;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= ST_EMPTY;
      idx_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      s_ready_q    <= 1'b0;
    end else begin
      st_q         <= st_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      s_ready_q    <= s_ready_d;
    end
  end

  // Shadow contents are don't-care until a full set has been written.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign s_ready    = s_ready_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign word_idx   = idx_q;

endmodule

// File: tb/tb_bias_loader_fc1.sv
// Bench for bias_loader_fc1: random and directed bias sets against a queue-based
// model of set assembly, with a scoreboard checking every commit/discard pulse.
module tb_bias_loader_fc1;
  localparam int N  = 16;
  localparam int W  = 32;
  localparam int DW = N * W;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          load_done;
  logic          load_error;
  logic [IW-1:0] word_idx;

  bias_loader_fc1 dut (
    .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .data(data), .data_valid(data_valid),
    .load_done(load_done), .load_error(load_error), .word_idx(word_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] d;
    bit            dv;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] mset[N];
  logic [W-1:0] pend[$];
  bit           mdv = 1'b0;
  bit           mrdy = 1'b0;
  logic [W-1:0] wbuf[N];
  int           total = 0;
  int           bad = 0;

  function automatic logic [DW-1:0] packm();
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = mset[k];
    return r;
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check.
  task automatic cycle(bit r, bit c, bit v, logic [W-1:0] d, bit l);
    bit hs;
    rst = r; clear = c; s_valid = v; s_data = d; s_last = l;
    @(posedge clk);
    chk("pulse_latency", expq.size(), 0);
    if (r) begin
      pend.delete();
      for (int k = 0; k < N; k++) mset[k] = '0;
      mdv  = 1'b0;
      mrdy = 1'b0;
    end else begin
      hs   = v && mrdy && !c;
      mrdy = 1'b1;
      if (c) begin
        pend.delete();
      end else if (hs) begin
        pend.push_back(d);
        if (l || pend.size() == N) begin
          if (l && pend.size() == N) begin
            for (int k = 0; k < N; k++) mset[k] = pend[k];
            mdv = 1'b1;
            expq.push_back('{1'b0, packm(), 1'b1});
          end else begin
            expq.push_back('{1'b1, packm(), mdv});
          end
          pend.delete();
        end
      end
    end
    #1;
    chk("word_idx", word_idx, pend.size());
    chk("data", data, packm());
    chk("data_valid", data_valid, mdv);
    chk("s_ready", s_ready, mrdy);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, $urandom, $urandom_range(0, 1));
  endtask

  // Sends wbuf[0..n-1], s_last on index last_at (-1: none), random gaps up to gap_max.
  task automatic send_set(int n, int last_at, int gap_max);
    for (int k = 0; k < n; k++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      cycle(1'b0, 1'b0, 1'b1, wbuf[k], k == last_at);
    end
  endtask

  task automatic rand_wbuf();
    for (int k = 0; k < N; k++) wbuf[k] = $urandom;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (load_done || load_error) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: done=%0b error=%0b expected no pulse", load_done, load_error);
      end else begin
        e = expq.pop_front();
        chk("pulse_done", load_done, !e.is_err);
        chk("pulse_error", load_error, e.is_err);
        chk("pulse_data", data, e.d);
        chk("pulse_data_valid", data_valid, e.dv);
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) mset[k] = '0;
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("reset_load_done", load_done, 0);
    chk("reset_load_error", load_error, 0);
    cycle(1'b1, 1'b0, 1'b1, '1, 1'b1);
    idle(1);

    // Basic load
    for (int k = 0; k < N; k++) wbuf[k] = 32'h1000_0000 + k;
    send_set(N, N - 1, 0);
    idle(2);

    // Gapped load, same data
    send_set(N, N - 1, 3);
    idle(1);

    // Early last over loaded set A, then set B back-to-back with a gap mix
    rand_wbuf();
    send_set(N, N - 1, 0);
    rand_wbuf();
    send_set(5, 4, 0);
    rand_wbuf();
    send_set(N, N - 1, 1);

    // Missing last
    rand_wbuf();
    send_set(N, -1, 0);
    idle(1);

    // Clear during word 7, then a fresh set
    rand_wbuf();
    send_set(7, -1, 0);
    cycle(1'b0, 1'b1, 1'b1, wbuf[7], 1'b0);
    rand_wbuf();
    send_set(N, N - 1, 0);

    // Reset at word 10 of a reload, then reload
    rand_wbuf();
    send_set(N, N - 1, 0);
    rand_wbuf();
    send_set(10, -1, 0);
    cycle(1'b1, 1'b0, 1'b1, wbuf[10], 1'b0);
    idle(1);
    rand_wbuf();
    send_set(N, N - 1, 0);

    // Random mix of well-formed, short, unterminated and cleared sets
    for (int s = 0; s < 30; s++) begin
      int kind;
      rand_wbuf();
      kind = $urandom_range(0, 5);
      if (kind <= 2)      send_set(N, N - 1, $urandom_range(0, 2));
      else if (kind == 3) begin
        int n = $urandom_range(1, N - 1);
        send_set(n, n - 1, 1);
      end else if (kind == 4) send_set(N, -1, 1);
      else begin
        send_set($urandom_range(1, N - 1), -1, 1);
        cycle(1'b0, 1'b1, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(2);
    chk("scoreboard_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bias_loader_fc1.md
# bias_loader_fc1

Runtime bias loader for the fc1 layer. Accepts fc1 bias words one neuron at a time over a valid/ready stream and packs them into the 512-bit packed bias vector, 16 neurons × 32 bits, consumed by the fc1 compute datapath. It replaces the static memory-image bias source, so biases can be reprogrammed without resynthesis. A partially loaded set is never visible to the datapath.

## Interface
- `NUM_NEURONS`, default 16: neurons per bias set.
- `BIAS_WIDTH`, default 32: bits per neuron bias, two's complement, passed through unmodified.
- `DATA_WIDTH`, default `NUM_NEURONS*BIAS_WIDTH` (512): packed output width.
- `IDX_WIDTH`, default `$clog2(NUM_NEURONS)` (4): word index width.
- `clk`, input, 1: sole clock; all logic updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `clear`, input, 1: synchronously aborts any partial load.
- `s_valid`, input, 1: a bias word is offered.
- `s_ready`, output, 1: the loader can accept a word.
- `s_data`, input, `BIAS_WIDTH`: bias for the neuron at `word_idx`.
- `s_last`, input, 1: marks the final word of a set.
- `data`, output, `DATA_WIDTH`: committed packed biases; neuron k occupies `[k*BIAS_WIDTH +: BIAS_WIDTH]`.
- `data_valid`, output, 1: at least one complete set has been committed since reset.
- `load_done`, output, 1: one-cycle pulse when a set commits.
- `load_error`, output, 1: one-cycle pulse when a set is discarded as malformed.
- `word_idx`, output, `IDX_WIDTH`: index of the next word to be accepted.

## Operation
- A handshake occurs on a rising edge where `s_valid && s_ready && !clear`.
- **State machine (`st`):**
  - EMPTY: after reset, no set committed.
  - FILL: at least one word of the current set accepted.
  - LOADED: a set is committed and no new set has been started.
- **Shadow buffer.** A handshake at index i<15 writes `s_data` into shadow slot i, increments `word_idx`, and sets `st`=FILL.
- **Commit.** A handshake at i=15 with `s_last`=1 copies shadow slots 0..14 plus `s_data` into slot 15 of `data`, all on the same edge. On that edge: `data_valid`←1, `load_done` pulses, `word_idx`←0, `st`←LOADED.
- **Malformed set, discard.** Either case below discards the set:
  - `s_last`=1 at i<15;
  - `s_last`=0 at i=15.
  
  On discard: `load_error` pulses, `word_idx`←0, and `st` returns to LOADED if `data_valid`, otherwise EMPTY. `data` is untouched.
- **`clear`.** Any word offered in the same cycle is dropped. `word_idx`←0 and the shadow contents become don't-care. `st` goes to LOADED/EMPTY by the same `data_valid` rule. `data` and `data_valid` are unchanged. No pulse is generated.
- **Reload.** A new set may start in LOADED at any time. The old `data` stays stable until the new commit edge.
- `s_ready` is a register: 0 while `rst` is high and in the cycle `rst` is sampled, 1 thereafter. It never depends combinationally on `s_valid`.
- The shadow buffer is not reset. Only control state and `data` are reset.

## Timing
- **Reset values:** `s_ready`=0, `data`=0, `data_valid`=0, `load_done`=0, `load_error`=0, `word_idx`=0, `st`=EMPTY.
- **Throughput:** one word per cycle. A full set takes 16 handshake cycles.
- **Commit latency:** `data`, `data_valid` and `load_done` reflect the new set in the cycle immediately after the edge that accepts word 15.
- **Back-to-back sets:** word 0 of the next set may be handshaked in the cycle immediately after the commit edge, with no bubble.
- `load_done` and `load_error` are never high in the same cycle.
- **`rst` mid-load:** overrides everything, including a same-cycle commit. All outputs take their reset values on that edge.
- **`clear` and `rst` together:** `rst` wins.
- **Stalls:** `s_valid` low cycles in FILL hold `word_idx` and the shadow contents indefinitely. There is no timeout.

## Test plan
- **Basic load.** After reset, stream words 0x1000_0000+k for k=0..15, with `s_last` on k=15 and `s_valid` high continuously.
  - Required: `load_done` pulses exactly once, the cycle after word 15; `data[k*32+:32]`=0x1000_0000+k; `data_valid`=1.
  - Before that cycle, `data`=0.
- **Gapped load.** Insert idle cycles randomly between words with the same data.
  - Required: identical final `data`; `word_idx` holds during gaps.
- **Early last.** With set A loaded, send 5 words with `s_last` on word 4.
  - Required: `load_error` pulses; `data` still equals A; `word_idx`=0.
  - A following well-formed set B then commits correctly.
- **Missing last.** Send 16 words with no `s_last`.
  - Required: `load_error` on word 15; `data` unchanged; `data_valid` unchanged.
- **Clear mid-load.** Assert `clear` during word 7, with `s_valid` high, then send a full new set.
  - Required: word 7 is dropped; no pulse at the `clear`; the new set commits with exact values, not mixed with the pre-`clear` words.
- **Reset mid-load and reload.** Assert `rst` for 1 cycle while at word 10 of a reload over committed set A.
  - Required: `data`=0, `data_valid`=0, `s_ready`=0 for one cycle after reset.
  - A subsequent full set then commits normally.
